// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter in front of a single shared memory.
//   Serves one request at a time through a three-state FSM:
//   IDLE (grant) -> ACCESS (one memory strobe cycle) -> DONE (ack pulse).
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   req0, addr0       : port 0 (instruction fetch), read-only
//   req1, we1, addr1,
//   wdata1            : port 1 (data), read or write
//   ack0/ack1         : one-cycle completion pulse per port
//   err0/err1         : valid with ack; 1 = misaligned or out-of-range
//   rdata0/rdata1     : registered read data, held until the next good read
//   MemAddress,
//   MemWriteData,
//   MemWrite, MemRead : memory side, active only in ACCESS
//   MemoryOut         : combinational memory read data (little-endian word)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 32'd2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemoryOut
);

  localparam logic [31:0] LP_MAX_ADDR = 32'(MEM_BYTES - 32'd4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_owner;  // 0 = port 0, 1 = port 1
  logic   r_we;
  logic   r_err;
  logic   r_last;   // port that received the most recent grant

  logic        w_grant1;
  logic [31:0] w_addr;
  logic        w_we;
  logic [31:0] w_wdata;
  logic        w_err;

  // Port 1 wins when alone, or when both request and port 0 was served last.
  assign w_grant1 = req1 & (~req0 | ~r_last);
  assign w_addr   = w_grant1 ? addr1 : addr0;
  // Port 0 is read-only, so its write enable and data are forced off.
  assign w_we     = w_grant1 & we1;
  assign w_wdata  = w_we ? wdata1 : 32'd0;
  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr > LP_MAX_ADDR);

  // Arbitration FSM with all outputs registered; reset clears strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_last       <= 1'b1;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= 32'd0;
      rdata1       <= 32'd0;
      MemAddress   <= 32'd0;
      MemWriteData <= 32'd0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err0 <= 1'b0;
          err1 <= 1'b0;
          if (req0 || req1) begin
            r_owner      <= w_grant1;
            r_we         <= w_we;
            r_err        <= w_err;
            // Memory-side registers are loaded here so they are live during ACCESS.
            MemAddress   <= w_addr;
            MemWriteData <= w_wdata;
            MemRead      <= ~w_we & ~w_err;
            MemWrite     <= w_we & ~w_err;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_we && !r_err) begin
            if (r_owner) begin
              rdata1 <= MemoryOut;
            end else begin
              rdata0 <= MemoryOut;
            end
          end
          MemAddress   <= 32'd0;
          MemWriteData <= 32'd0;
          MemRead      <= 1'b0;
          MemWrite     <= 1'b0;
          ack0         <= ~r_owner;
          ack1         <= r_owner;
          err0         <= ~r_owner & r_err;
          err1         <= r_owner & r_err;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: begin
          ack0         <= 1'b0;
          ack1         <= 1'b0;
          err0         <= 1'b0;
          err1         <= 1'b0;
          MemAddress   <= 32'd0;
          MemWriteData <= 32'd0;
          MemRead      <= 1'b0;
          MemWrite     <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0;
  logic [31:0] addr0;
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] MemAddress, MemWriteData;
  logic        MemWrite, MemRead;
  logic [31:0] MemoryOut;

  mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .MemoryOut(MemoryOut)
  );

  always #5 clk = ~clk;

  // Environment memory, driven by the DUT strobes
  logic [7:0] mem [MEM_BYTES];
  // Reference copy, updated only by the model's predictions
  logic [7:0] ref_mem [MEM_BYTES];

  always_comb begin
    MemoryOut = 32'd0;
    if (MemAddress <= 32'(MEM_BYTES - 4))
      MemoryOut = {mem[MemAddress + 32'd3], mem[MemAddress + 32'd2],
                   mem[MemAddress + 32'd1], mem[MemAddress]};
  end

  always @(posedge clk) begin
    if (MemWrite && MemAddress <= 32'(MEM_BYTES - 4)) begin
      mem[MemAddress]         <= MemWriteData[7:0];
      mem[MemAddress + 32'd1] <= MemWriteData[15:8];
      mem[MemAddress + 32'd2] <= MemWriteData[23:16];
      mem[MemAddress + 32'd3] <= MemWriteData[31:24];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { bit port; bit err; logic [31:0] rdata; int cyc; } ack_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  ack_t ack_q[$];
  acc_t acc_q[$];

  // Reference model state
  bit          m_last;
  logic [31:0] m_rdata [2];

  function automatic bit m_err(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a > 32'(MEM_BYTES - 4));
  endfunction

  task automatic predict(input bit port, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_cyc);
    ack_t e;
    acc_t s;
    bit bad;
    bad = m_err(a);
    if (!bad) begin
      s.we = we; s.addr = a; s.wdata = wd;
      acc_q.push_back(s);
      if (we) begin
        for (int b = 0; b < 4; b++) ref_mem[a + b] = wd[8*b +: 8];
      end else begin
        m_rdata[port] = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
      end
    end
    e.port = port; e.err = bad; e.rdata = m_rdata[port]; e.cyc = ack_cyc;
    ack_q.push_back(e);
  endtask

  // Issue c0 port-0 reads and c1 port-1 accesses, requests held high until served.
  // Called at a negedge while the DUT is idle.
  task automatic run_batch(input int c0, input logic [31:0] a0, input int c1,
                           input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    int  n0, n1, samp;
    bit  win, got;
    n0 = c0; n1 = c1;
    req0 = (n0 > 0); addr0 = a0;
    req1 = (n1 > 0); we1 = w1; addr1 = a1; wdata1 = d1;
    samp = cyc + 1;
    while (n0 > 0 || n1 > 0) begin
      win = (n0 > 0 && n1 > 0) ? !m_last : (n1 > 0);
      if (win) predict(1'b1, w1, a1, d1, samp + 1);
      else     predict(1'b0, 1'b0, a0, 32'd0, samp + 1);
      m_last = win;
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          got = 1'b1;
          break;
        end
      end
      chk("ack_wait", {31'd0, got}, 32'd1);
      if (win) begin n1--; req1 = (n1 > 0); end
      else     begin n0--; req0 = (n0 > 0); end
      samp = samp + 3;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)       return 32'($urandom_range(0, 15) * 4);
    else if (r < 7)  return 32'($urandom_range(0, MEM_BYTES / 4 - 1) * 4);
    else if (r == 7) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    else if (r == 8) return 32'(MEM_BYTES - 4 + $urandom_range(0, 8));
    else             return $urandom;
  endfunction

  // Monitor: checks memory strobes and acks against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (MemRead || MemWrite) begin
        chk("strobe_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        if (acc_q.size() == 0) begin
          chk("strobe_unexpected", {31'd0, MemRead | MemWrite}, 32'd0);
        end else begin
          acc_t s;
          s = acc_q.pop_front();
          chk("mem_write", {31'd0, MemWrite}, {31'd0, s.we});
          chk("mem_read", {31'd0, MemRead}, {31'd0, !s.we});
          chk("mem_addr", MemAddress, s.addr);
          if (s.we) chk("mem_wdata", MemWriteData, s.wdata);
        end
      end
      if (ack0 || ack1) begin
        chk("ack_both", {31'd0, ack0 & ack1}, 32'd0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
          chk("ack_cycle", cyc, e.cyc);
          chk("err", {31'd0, e.port ? err1 : err0}, {31'd0, e.err});
          chk("rdata", e.port ? rdata1 : rdata0, e.rdata);
          chk("done_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
          chk("done_addr", MemAddress, 32'd0);
          chk("done_wdata", MemWriteData, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    rst = 1'b1; req0 = 1'b0; addr0 = 32'd0; req1 = 1'b0; we1 = 1'b0;
    addr1 = 32'd0; wdata1 = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8] = 8'h44; mem[9] = 8'h33; mem[10] = 8'h22; mem[11] = 8'h11;
    for (int i = 8; i < 12; i++) ref_mem[i] = mem[i];
    m_last = 1'b1; m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_ack_err", {28'd0, ack0, ack1, err0, err1}, 32'd0);
    chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_addr", MemAddress, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read, write-then-read, contention, errors, boundary
    run_batch(1, 32'h8, 0, 1'b0, 32'd0, 32'd0);
    run_batch(0, 32'd0, 1, 1'b1, 32'h10, 32'hDEADBEEF);
    run_batch(0, 32'd0, 1, 1'b0, 32'h10, 32'd0);
    run_batch(2, 32'h8, 2, 1'b0, 32'h10, 32'd0);
    run_batch(0, 32'd0, 1, 1'b1, 32'h6, 32'h12345678);
    run_batch(0, 32'd0, 1, 1'b0, 32'(MEM_BYTES - 2), 32'd0);
    run_batch(1, 32'(MEM_BYTES - 4), 0, 1'b0, 32'd0, 32'd0);
    run_batch(0, 32'd0, 1, 1'b0, 32'(MEM_BYTES - 4), 32'd0);

    // Reset in the ACCESS cycle of a port 1 write
    saved = {mem[32'h43], mem[32'h42], mem[32'h41], mem[32'h40]};
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk("rst_mid_mw_before", {31'd0, MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mw_async", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("rst_mid_mem", {mem[32'h43], mem[32'h42], mem[32'h41], mem[32'h40]}, saved);
    m_last = 1'b1; m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
    rst = 1'b0;
    @(negedge clk);
    run_batch(1, 32'h8, 1, 1'b0, 32'h10, 32'd0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      int c0, c1;
      c0 = $urandom_range(0, 2);
      c1 = $urandom_range(0, 2);
      if (c0 == 0 && c1 == 0) c0 = 1;
      run_batch(c0, rand_addr(), c1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("ack_q_drained", ack_q.size(), 32'd0);
    chk("acc_q_drained", acc_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
